// File: rtl/prio_arbiter_rr_pkg.sv
// Shared types and constants for the prio_arbiter_rr arbiter slice.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/prio_arbiter_rr_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface prio_arbiter_rr_if #(
  parameter int N = 4
);
  import arb_pkg::*;

  logic                 en;
  logic                 mode;
  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic [$clog2(N)-1:0] gnt_idx;
  logic                 busy;

  modport master (
    output en, mode, req,
    input  gnt, gnt_idx, busy
  );

  modport slave (
    input  en, mode, req,
    output gnt, gnt_idx, busy
  );

endinterface : prio_arbiter_rr_if

// File: rtl/prio_arbiter_rr_pick.sv
// Masked priority encoder: highest set index in fixed mode, or the first set
// index found walking upward from start (wrapping mod N) in round-robin mode.
module prio_pick
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  input  logic                 mode,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // Pick one requester; later loop iterations overwrite earlier ones, so the
  // loop order encodes the priority.
  always_comb begin
    int pos;
    // NOTE: every variable gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch can be inferred.
    pos   = 0;
    found = |req;
    idx   = '0;
    if (mode == ARB_MODE_FIXED) begin
      for (int i = 0; i < N; i++) begin
        if (req[IW'(i)]) idx = IW'(i);
      end
    end else begin
      // Walk from the farthest offset back to the nearest so the nearest wins.
      for (int k = N - 1; k >= 0; k--) begin
        pos = int'(start) + k;
        if (pos >= N) pos = pos - N;
        if (req[IW'(pos)]) idx = IW'(pos);
      end
    end
  end

endmodule : prio_pick

// File: rtl/prio_arbiter_rr.sv
// N-requester arbiter with registered one-hot grants, grant locking and an
// optional round-robin hold limit that preempts a holder when others wait.
module prio_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  prio_arbiter_rr_if.slave bus
);

  localparam int IW = $clog2(N);
  // A zero MAX_HOLD still needs a one-bit counter to keep the logic legal.
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam logic [N-1:0]  ONE       = N'(1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [IW-1:0] start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          others;

  // Round-robin search begins just past the most recent winner.
  assign start  = (last_q == IDX_TOP) ? '0 : last_q + 1'b1;
  // Some requester other than the current holder is waiting.
  assign others = |(bus.req & ~gnt_q);

  prio_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .start (start),
    .mode  (bus.mode),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and next-grant decision for the two-state grant FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        idx_d = '0;
        if (bus.en && pick_found) begin
          state_d = ARB_GRANT;
          gnt_d   = ONE << pick_idx;
          idx_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
        end
      end
      ARB_GRANT: begin
        if (!bus.req[idx_q]) begin
          // Holder released: hand over directly, or fall back to idle.
          if (bus.en && others) begin
            gnt_d  = ONE << pick_idx;
            idx_d  = pick_idx;
            last_d = pick_idx;
            hold_d = '0;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            hold_d  = '0;
          end
        end else if (bus.mode == ARB_MODE_RR && MAX_HOLD != 0 &&
                     hold_q == HOLD_LAST && others && bus.en) begin
          // Hold limit reached with others waiting; the RR search ends at the
          // holder, so it can only be re-picked if nobody else requests.
          gnt_d  = ONE << pick_idx;
          idx_d  = pick_idx;
          last_d = pick_idx;
          hold_d = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and grant registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_TOP;
      hold_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = |gnt_q;

endmodule : prio_arbiter_rr
